tick_period_meter: RTL
======================

// Module: tick_period_meter
// PURPOSE
//   Receive side of the periodic-tick interface: measures the cycle distance between
//   successive 1-cycle tick strobes (as produced by the period counter's overflow).
//   Reports each measured period, flags a lost tick stream (timeout), and asserts a lock
//   indication once the stream is stable around the expected period. Used to check and
//   monitor tick sources in the pipeline's timing path.
// PARAMETERS
//   PERIOD      1000  expected tick period in clk cycles (>= 2)
//   TOL         2     accepted deviation, +/- cycles (0 <= TOL < PERIOD)
//   LOCK_COUNT  4     consecutive in-tolerance measurements required to lock (>= 1)
//   (local) CW = $clog2(2*PERIOD + 1)   counter/period width
// PORTS
//   clk           in   1   clock, all logic on posedge
//   rst_n         in   1   synchronous reset, active-low
//   tick          in   1   tick strobe; each cycle sampled high counts as one tick
//   period        out  CW  last measured period in cycles; holds until next measurement
//   period_valid  out  1   1-cycle pulse: period updated
//   timeout       out  1   1-cycle pulse: no tick within 2*PERIOD cycles
//   locked        out  1   level: LOCK_COUNT consecutive good measurements seen
// BEHAVIOUR
//   - One clock, synchronous active-low reset. rst_n low at an edge forces:
//     state=IDLE, cnt=0, good_cnt=0, period=0, period_valid=0, timeout=0, locked=0.
//     Reset mid-measurement discards the partial count; the next tick is the first tick.
//   - All outputs registered. Timing is counted in sampling edges: tick sampled high at edge k.
//   - States:
//     IDLE:    no reference tick yet. tick -> MEASURE, cnt<=1. No period_valid.
//     MEASURE: no tick -> cnt<=cnt+1. tick -> period<=cnt, period_valid<=1, cnt<=1.
//   - Period definition: ticks sampled at edges k and k+N -> period=N.
//     period_valid is high in the cycle after edge k+N (latency 1).
//   - Tick held high for M cycles in MEASURE -> M measurements of period=1.
//   - Timeout: in MEASURE, cnt==2*PERIOD and tick low at edge e -> timeout<=1 for 1 cycle,
//     state<=IDLE, cnt<=0, good_cnt<=0, locked<=0. period keeps its last value.
//     If tick is high at that same edge, it is a normal measurement (period=2*PERIOD),
//     no timeout.
//     cnt never exceeds 2*PERIOD, so no wrap-around.
//   - Lock evaluation on every measurement:
//     good = (PERIOD-TOL <= cnt <= PERIOD+TOL), compared at full CW width.
//     - good:  good_cnt <= min(good_cnt+1, LOCK_COUNT). locked<=1 when the new value
//              == LOCK_COUNT, in the same cycle as period_valid.
//     - !good: good_cnt<=0 and locked<=0, in the same cycle as period_valid.
//   - locked changes only on a measurement, a timeout or a reset.
//   - timeout and period_valid are never high in the same cycle.
// TESTING
//   1. Reset; ticks every 1000 cycles x6 -> no valid on 1st tick; 5 pulses period=1000;
//      locked rises with the 4th valid (5th tick).
//   2. Locked; gaps 1001,998,1003 -> 1001,998 keep lock;
//      1003 drops locked with its valid, good_cnt=0.
//   3. Locked; ticks stop -> timeout high exactly 1 cycle, after edge last_tick+2000;
//      locked=0; next tick gives no valid.
//   4. Gap of exactly 2000 cycles -> period=2000, period_valid=1, timeout=0,
//      locked cleared (out of range).
//   5. tick held high 3 cycles from IDLE -> two period_valid pulses with period=1.
//   6. rst_n low 1 cycle at cnt=500 -> all outputs 0; next tick gives no valid;
//      the tick after it 1000 cycles later gives period=1000.

Source files
------------

// File: rtl/tick_period_meter_if.sv
// Periodic-tick receive interface: tick strobe in, measurement results out.
//   tick          tick strobe from the tick source
//   period        last measured period in clk cycles (CW bits)
//   period_valid  1-cycle pulse when period updates
//   timeout       1-cycle pulse when the tick stream is lost
//   locked        level, stream stable around the expected period
interface tick_period_meter_if #(
  parameter int unsigned CW = 11
);
  logic          tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          timeout;
  logic          locked;

  // Tick source / result consumer side
  modport master (
    output tick,
    input  period,
    input  period_valid,
    input  timeout,
    input  locked
  );

  // Meter side
  modport slave (
    input  tick,
    output period,
    output period_valid,
    output timeout,
    output locked
  );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the cycle distance between successive tick strobes, reports each period,
// pulses timeout when no tick arrives within 2*PERIOD cycles, and asserts locked after
// LOCK_COUNT consecutive measurements within PERIOD +/- TOL.
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  synchronous reset, active-low
//   bus    tick_period_meter_if.slave (tick in; period, period_valid, timeout, locked out)
module tick_period_meter #(
  parameter int unsigned PERIOD     = 1000,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tick_period_meter_if.slave      bus
);

  localparam int unsigned CW = $clog2(2 * PERIOD + 1);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(2 * PERIOD);
  localparam logic [CW-1:0] GOOD_LO = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] GOOD_HI = CW'(PERIOD + TOL);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic [0:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [GW-1:0] good_q,   good_d;
  logic [CW-1:0] period_q, period_d;
  logic          pv_q,     pv_d;
  logic          to_q,     to_d;
  logic          locked_q, locked_d;

  logic          in_tol_c;
  logic [GW-1:0] good_inc_c;

  // Tolerance window on the count being reported as a period
  assign in_tol_c = (cnt_q >= GOOD_LO) && (cnt_q <= GOOD_HI);

  // Saturating good-measurement count
  assign good_inc_c = (good_q < GOOD_MAX) ? good_q + GW'(1) : GOOD_MAX;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      to_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      to_q     <= to_d;
      locked_q <= locked_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    period_d = period_q;
    pv_d     = 1'b0;
    to_d     = 1'b0;
    locked_d = locked_q;

    case (state_q)
      IDLE: begin
        // First tick only sets the reference point
        if (bus.tick) begin
          state_d = MEASURE;
          cnt_d   = CW'(1);
        end
      end
      MEASURE: begin
        if (bus.tick) begin
          // A tick on the timeout edge still counts as a measurement
          period_d = cnt_q;
          pv_d     = 1'b1;
          cnt_d    = CW'(1);
          if (in_tol_c) begin
            good_d   = good_inc_c;
            locked_d = (good_inc_c == GOOD_MAX);
          end else begin
            good_d   = '0;
            locked_d = 1'b0;
          end
        end else if (cnt_q == CNT_MAX) begin
          to_d     = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
          good_d   = '0;
          locked_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.timeout      = to_q;
  assign bus.locked       = locked_q;

endmodule
